// File: rtl/uart_pkg.sv
// Types, constants and helpers shared by the UART transmit and receive paths.
package uart_pkg;

  // Transmit sequencer states; 3 bits leaves room for a receiver's extra states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Widest character the parity helper accepts; narrower data is zero-extended.
  localparam int MAX_DATA_WIDTH = 16;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Free-run while a frame is active, wrap at every bit boundary, hold at zero when cleared.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_end = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and
// serialises them as start / data (LSB first) / optional parity / stop frames.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  // One counter serves both the data-bit index and the stop-bit index.
  localparam int            BW        = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_parity;

  logic                  w_baud_clear;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // The baud timer is held at zero while idle so a frame always starts on a fresh bit.
  assign w_baud_clear = (r_state == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_baud_clear),
    .o_bit_end (w_bit_end)
  );

  assign w_frame_end  = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
  assign w_shift_next = r_shift >> 1;

  // NOTE: the pop strobe is combinational so it lines up with the FWFT data it consumes;
  // it is gated by rst because the FSM sits in IDLE during reset and would otherwise pop.
  assign w_pop        = !rst && i_en && !i_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);
  assign o_fifo_rd_en = w_pop;
  assign o_tx_done    = w_frame_end;

  // Frame sequencer: captures the FIFO head at the pop and walks the line through each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift  <= i_fifo_data;
            r_parity <= calc_parity(MAX_DATA_WIDTH'(i_fifo_data), PAR_ODD);
            r_state  <= ST_START;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            o_tx      <= r_shift[0];
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= ST_PARITY;
                o_tx    <= r_parity;
              end else begin
                r_state <= ST_STOP;
                o_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_shift   <= w_shift_next;
              o_tx      <= w_shift_next[0];
            end
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_state   <= ST_STOP;
            r_bit_cnt <= '0;
            o_tx      <= 1'b1;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              if (w_pop) begin
                // Back-to-back: the next start bit follows the last stop bit directly.
                r_shift  <= i_fifo_data;
                r_parity <= calc_parity(MAX_DATA_WIDTH'(i_fifo_data), PAR_ODD);
                r_state  <= ST_START;
                o_tx     <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                o_tx    <= 1'b1;
                o_busy  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: three transmitter configurations (8N1, 8E1, 8O2), each fed by
// its own FWFT FIFO model, with hand-computed expected line waveforms.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en  = '0;

  logic [2:0] fifo_empty;
  logic [2:0] rd_en;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] fifo_data [3];

  // FWFT FIFO storage, one 16-deep queue per transmitter.
  logic [7:0] mem     [3][16];
  logic [4:0] wp      [3] = '{default: '0};
  logic [4:0] rp      [3] = '{default: '0};
  logic [2:0] wr_en       = '0;
  logic [7:0] wr_data [3] = '{default: '0};

  int checks = 0;
  int errors = 0;

  // Per-cycle capture of one transmitter, index 0 = the pop cycle.
  logic s_tx    [200];
  logic s_rd    [200];
  logic s_done  [200];
  logic s_busy  [200];
  logic s_empty [200];

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .CLKS_PER_BIT (CPB)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en[0]),
    .i_fifo_empty (fifo_empty[0]),
    .i_fifo_data  (fifo_data[0]),
    .o_fifo_rd_en (rd_en[0]),
    .o_tx         (tx[0]),
    .o_busy       (busy[0]),
    .o_tx_done    (done[0])
  );

  uart_tx_fifo_drain #(
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1),
    .PARITY_ODD   (0),
    .STOP_BITS    (1)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en[1]),
    .i_fifo_empty (fifo_empty[1]),
    .i_fifo_data  (fifo_data[1]),
    .o_fifo_rd_en (rd_en[1]),
    .o_tx         (tx[1]),
    .o_busy       (busy[1]),
    .o_tx_done    (done[1])
  );

  uart_tx_fifo_drain #(
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1),
    .PARITY_ODD   (1),
    .STOP_BITS    (2)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en[2]),
    .i_fifo_empty (fifo_empty[2]),
    .i_fifo_data  (fifo_data[2]),
    .o_fifo_rd_en (rd_en[2]),
    .o_tx         (tx[2]),
    .o_busy       (busy[2]),
    .o_tx_done    (done[2])
  );

  // FIFO write and pop pointers.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en[k]) begin
        mem[k][wp[k][3:0]] <= wr_data[k];
        wp[k]              <= wp[k] + 5'd1;
      end
      if (rd_en[k] && !fifo_empty[k]) begin
        rp[k] <= rp[k] + 5'd1;
      end
    end
  end

  // FWFT head and empty flag.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      fifo_empty[k] = (wp[k] == rp[k]);
      fifo_data[k]  = mem[k][rp[k][3:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  task automatic push(input int idx, input logic [7:0] b);
    wr_en[idx]   = 1'b1;
    wr_data[idx] = b;
    @(negedge clk); #1;
    wr_en[idx]   = 1'b0;
  endtask

  // Returns at the pop cycle (sampling point) or after max_cyc cycles with ok = 0.
  task automatic wait_pop(input int idx, input int max_cyc, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < max_cyc; i++) begin
      if (rd_en[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // Capture n cycles starting at the current sampling point; drop en at sample drop_at.
  task automatic record(input int idx, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      s_tx[i]    = tx[idx];
      s_rd[i]    = rd_en[idx];
      s_done[i]  = done[idx];
      s_busy[i]  = busy[idx];
      s_empty[i] = fifo_empty[idx];
      if (i == drop_at) en[idx] = 1'b0;
      @(negedge clk); #1;
    end
  endtask

  // Sampling receiver: mid-bit samples of a frame whose start bit begins at sample base.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = s_tx[base + CPB * (b + 1) + 2];
    return d;
  endfunction

  task automatic test_reset;
    push(0, 8'hA5);
    en[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: tx=%b busy=%b rd_en=%b, want tx=1 busy=0 rd_en=0",
                 c, tx[0], busy[0], rd_en[0]);
      end
      @(negedge clk); #1;
    end
    en[0] = 1'b0;
    rst   = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: tx=%b busy=%b empty=%b, want tx=1 busy=0 empty=0",
               tx[0], busy[0], fifo_empty[0]);
    end
  endtask

  task automatic test_single;
    bit         ok;
    int         n_rd;
    int         n_done;
    int         bad;
    logic [9:0] exp_line;
    exp_line = 10'b1101001010;  // 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1
    en[0] = 1'b1;
    wait_pop(0, 5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_pop_timeout: rd_en=0, want a pop within 5 cycles");
    end
    record(0, 42, -1);
    en[0] = 1'b0;
    checks++;
    if (s_tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_line_latency: tx in pop cycle=%b, want 1", s_tx[0]);
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) if (s_tx[1 + CPB * b + c] !== exp_line[b]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_bit%0d: %0d of 4 cycles differ, want level %b", b, bad, exp_line[b]);
      end
    end
    n_rd   = 0;
    n_done = 0;
    for (int i = 0; i < 42; i++) begin
      if (s_rd[i] === 1'b1) n_rd++;
      if (s_done[i] === 1'b1) n_done++;
    end
    checks++;
    if (n_rd != 1 || s_rd[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_pop_count: pops=%0d first=%b, want 1 pop in pop cycle", n_rd, s_rd[0]);
    end
    checks++;
    if (n_done != 1 || s_done[40] !== 1'b1) begin
      errors++;
      $display("FAIL single_done: pulses=%0d at40=%b, want one pulse at cycle 40", n_done, s_done[40]);
    end
    bad = 0;
    for (int i = 1; i <= 40; i++) if (s_busy[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || s_busy[41] !== 1'b0 || s_tx[41] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: low cycles in frame=%0d busy_after=%b tx_after=%b, want 0/0/1",
               bad, s_busy[41], s_tx[41]);
    end
  endtask

  task automatic test_back_to_back;
    bit         ok;
    int         n_rd;
    int         n_done;
    int         bad;
    logic [7:0] got;
    logic [7:0] exp_b [3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en[0] = 1'b1;
    wait_pop(0, 5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_pop_timeout: rd_en=0, want a pop within 5 cycles");
    end
    record(0, 122, -1);
    en[0] = 1'b0;
    n_rd   = 0;
    n_done = 0;
    for (int i = 0; i < 122; i++) begin
      if (s_rd[i] === 1'b1) n_rd++;
      if (s_done[i] === 1'b1) n_done++;
    end
    checks++;
    if (n_rd != 3 || s_rd[0] !== 1'b1 || s_rd[40] !== 1'b1 || s_rd[80] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pops: count=%0d at0/40/80=%b%b%b, want 3 pops at 0,40,80",
               n_rd, s_rd[0], s_rd[40], s_rd[80]);
    end
    checks++;
    if (n_done != 3 || s_done[40] !== 1'b1 || s_done[80] !== 1'b1 || s_done[120] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: count=%0d at40/80/120=%b%b%b, want 3 pulses at 40,80,120",
               n_done, s_done[40], s_done[80], s_done[120]);
    end
    bad = 0;
    for (int i = 1; i <= 120; i++) if (s_busy[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || s_busy[121] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_contiguous: busy low in %0d frame cycles, busy_after=%b, want 0 and 0",
               bad, s_busy[121]);
    end
    for (int f = 0; f < 3; f++) begin
      got = decode(1 + 40 * f);
      checks++;
      if (got !== exp_b[f] || s_tx[1 + 40 * f + 2] !== 1'b0 || s_tx[1 + 40 * f + 38] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame%0d: data=%h start=%b stop=%b, want data=%h start=0 stop=1",
                 f, got, s_tx[1 + 40 * f + 2], s_tx[1 + 40 * f + 38], exp_b[f]);
      end
    end
    checks++;
    if (s_empty[81] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_fifo_empty: empty after third pop=%b, want 1", s_empty[81]);
    end
  endtask

  task automatic test_parity_stop;
    bit         ok;
    int         bad;
    int         n_done;
    logic [7:0] got;
    // Even parity, one stop bit: 0x07 has three ones, parity bit 1, frame 44 cycles.
    push(1, 8'h07);
    en[1] = 1'b1;
    wait_pop(1, 5, ok);
    record(1, 46, -1);
    en[1] = 1'b0;
    got = decode(1);
    checks++;
    if (!ok || got !== 8'h07) begin
      errors++;
      $display("FAIL even_data: pop_seen=%b data=%h, want 1 and 07", ok, got);
    end
    bad = 0;
    for (int i = 37; i <= 40; i++) if (s_tx[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL even_parity_bit: %0d of 4 cycles low, want parity 1", bad);
    end
    n_done = 0;
    for (int i = 0; i < 46; i++) if (s_done[i] === 1'b1) n_done++;
    checks++;
    if (n_done != 1 || s_done[44] !== 1'b1 || s_busy[45] !== 1'b0) begin
      errors++;
      $display("FAIL even_frame_len: pulses=%0d at44=%b busy45=%b, want 1/1/0",
               n_done, s_done[44], s_busy[45]);
    end
    // Odd parity, two stop bits: parity bit 0, stop high 8 cycles, frame 48 cycles.
    push(2, 8'h07);
    en[2] = 1'b1;
    wait_pop(2, 5, ok);
    record(2, 50, -1);
    en[2] = 1'b0;
    got = decode(1);
    checks++;
    if (!ok || got !== 8'h07) begin
      errors++;
      $display("FAIL odd_data: pop_seen=%b data=%h, want 1 and 07", ok, got);
    end
    bad = 0;
    for (int i = 37; i <= 40; i++) if (s_tx[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL odd_parity_bit: %0d of 4 cycles high, want parity 0", bad);
    end
    bad = 0;
    for (int i = 41; i <= 48; i++) if (s_tx[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL two_stop_level: %0d of 8 stop cycles low, want all high", bad);
    end
    n_done = 0;
    for (int i = 0; i < 50; i++) if (s_done[i] === 1'b1) n_done++;
    checks++;
    if (n_done != 1 || s_done[48] !== 1'b1 || s_busy[48] !== 1'b1 || s_busy[49] !== 1'b0) begin
      errors++;
      $display("FAIL two_stop_frame_len: pulses=%0d at48=%b busy48=%b busy49=%b, want 1/1/1/0",
               n_done, s_done[48], s_busy[48], s_busy[49]);
    end
  endtask

  task automatic test_enable_gating;
    bit         ok;
    int         n_rd;
    logic [7:0] got;
    push(0, 8'h3C);
    push(0, 8'h4D);
    en[0] = 1'b1;
    wait_pop(0, 5, ok);
    record(0, 60, 12);
    got = decode(1);
    checks++;
    if (!ok || got !== 8'h3C || s_done[40] !== 1'b1 || s_busy[41] !== 1'b0) begin
      errors++;
      $display("FAIL gate_completes: pop=%b data=%h done40=%b busy41=%b, want 1/3c/1/0",
               ok, got, s_done[40], s_busy[41]);
    end
    n_rd = 0;
    for (int i = 0; i < 60; i++) if (s_rd[i] === 1'b1) n_rd++;
    checks++;
    if (n_rd != 1 || s_empty[59] !== 1'b0) begin
      errors++;
      $display("FAIL gate_no_pop: pops=%0d empty=%b, want 1 pop and 4d still queued", n_rd, s_empty[59]);
    end
    en[0] = 1'b1;
    wait_pop(0, 3, ok);
    record(0, 42, -1);
    en[0] = 1'b0;
    got = decode(1);
    checks++;
    if (!ok || got !== 8'h4D) begin
      errors++;
      $display("FAIL gate_resume: pop=%b data=%h, want 1 and 4d", ok, got);
    end
  endtask

  task automatic test_mid_reset;
    bit         ok;
    logic [7:0] got;
    push(0, 8'h96);
    push(0, 8'h69);
    en[0] = 1'b1;
    wait_pop(0, 5, ok);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (!ok || tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_before: pop=%b tx in data bit 3=%b, want 1 and 0", ok, tx[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_immediate: tx=%b busy=%b rd_en=%b, want 1/0/0", tx[0], busy[0], rd_en[0]);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    wait_pop(0, 5, ok);
    record(0, 42, -1);
    en[0] = 1'b0;
    got = decode(1);
    checks++;
    if (!ok || got !== 8'h69) begin
      errors++;
      $display("FAIL midrst_next_byte: pop=%b data=%h, want 1 and 69", ok, got);
    end
  endtask

  initial begin
    @(negedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_stop();
    test_enable_gating();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
